pipe_ctl: RTL and testbench
===========================

// Module: pipe_ctl
// PURPOSE
//  Pipelined successor to the single-cycle main decoder for the 5-stage MIPS core. Decodes the ID-stage
//  instruction and carries control bundles through ID/EX, EX/MEM and MEM/WB registers. Detects load-use
//  hazards and inserts a parametrised number of stall cycles. Sequences illegal-op/IRQ exception entry and
//  ERET return with a supervisor-mode bit.
// PARAMETERS
//  REG_AW      5   register-address width (rs/rt/dest compare width)
//  LOAD_STALL  1   bubbles inserted per load-use hazard, legal 1..3 (memory latency)
//  IRQ_EN      1   1 = irq causes exception entry; 0 = irq ignored
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-high
//  irq        in   1       level interrupt request
//  opCode     in   6       ID instruction [31:26]
//  funct      in   6       ID instruction [5:0]
//  rs         in   REG_AW  ID instruction [25:21]
//  rt         in   REG_AW  ID instruction [20:16]
//  branchTaken in  1       EX resolved taken branch/jump redirect
//  pcWrite    out  1       PC register enable
//  ifIdWrite  out  1       IF/ID register enable
//  ifIdFlush  out  1       IF/ID clear to NOP
//  exCtl      out  12      ID/EX: {RegDst[1:0],ALUSrc,ALUOp[4:0],Branch,BranchControl,Jump[1:0]}
//  memCtl     out  2       EX/MEM: {MemWrite,MemRead}
//  wbCtl      out  2       MEM/WB: {RegWrite,MemToReg}
//  excPcSel   out  1       PC mux selects exception vector
//  epcWrite   out  1       capture ID-stage PC into EPC
//  supervisor out  1       supervisor-mode bit
//  illOp      out  1       registered 1-cycle illegal-instruction flag
// BEHAVIOUR
//  Reset (async): exCtl/memCtl/wbCtl=0, state=RUN, stallCnt=0, supervisor=0, illOp=0; while reset high
//   pcWrite=ifIdWrite=ifIdFlush=excPcSel=epcWrite=0.
//  Decode (comb, ID): R-type funct 000000/000010/000011 sll/srl/sra ALUOp 01000/01001/01011 ALUSrc=1;
//   add 00000, sub 00001, and 11000, or 11110, xor 10110, nor 10001, slt 00111, RegDst=00 RegWrite=1;
//   jr Jump=10; j 000010 Jump=01; jal 000011 RegDst=11 ALUOp=11010 RegWrite=1 Jump=01;
//   beq/bne 000100/000101 ALUOp=00001 Branch=1 BranchControl=0/1; addi/andi/ori/xori RegDst=01 ALUSrc=1
//   RegWrite=1 ALUOp 00000/11000/11110/10110; lw 100011 RegDst=01 ALUSrc=1 RegWrite MemRead MemToReg;
//   sw 101011 ALUSrc=1 MemWrite; eret opCode 010000 funct 011000 Jump=11 (legal only if supervisor=1).
//   Any other encoding (incl. eret in user mode) = illegal.
//  Bubble = all-zero bundle (no writes, no branch, no jump).
//  Pipeline: each edge ID/EX<=decode or bubble; EX/MEM<=ID/EX mem+wb fields; MEM/WB<=EX/MEM wb fields.
//   Internal ID/EX copies of MemRead and rt used for hazard compare. Decode-to-exCtl latency 1 cycle.
//  FSM states RUN, STALL, EXC. Priority per cycle: branchTaken > exception > load-use.
//   branchTaken=1: ifIdFlush=1, ID/EX<=bubble, stallCnt<=0, state<=RUN; any pending exception dropped.
//   Exception cond (RUN only): decoded illegal, or (irq & IRQ_EN & !supervisor). Go EXC: that cycle
//    excPcSel=1, epcWrite=1, ifIdFlush=1, ID/EX<=bubble, illOp<=illegal, supervisor<=1; next cycle RUN.
//   Load-use (RUN): ID/EX.MemRead & (ID/EX.rt==rs | ID/EX.rt==rt) & ID/EX.rt!=0 -> pcWrite=ifIdWrite=0,
//    ID/EX<=bubble, stallCnt<=LOAD_STALL-1; state<=STALL if LOAD_STALL>1 else RUN.
//   STALL: pcWrite=ifIdWrite=0, bubble, stallCnt--; at stallCnt==1 return RUN (total LOAD_STALL bubbles).
//   eret issued in RUN with supervisor=1: supervisor<=0 on that edge.
//  Default outputs: pcWrite=ifIdWrite=1, others 0. illOp clears next cycle.
//  Reset mid-stall/EXC aborts immediately to reset values; no partial state survives.
// TESTING
//  reset asserted mid-STALL -> all outputs 0 same cycle; after release exCtl=0, state RUN, supervisor=0.
//  lw $2 then add $3,$2,$4 (LOAD_STALL=1) -> 1 cycle pcWrite=0, exCtl=0 bubble, then add exCtl ALUOp=00000.
//  same with LOAD_STALL=3 -> exactly 3 bubbles; lw to $0 -> no stall.
//  opCode 111111 in RUN -> excPcSel=epcWrite=ifIdFlush=1 one cycle, illOp=1 next, supervisor=1.
//  irq=1 with illegal op in ID and branchTaken=1 same cycle -> flush only, no epcWrite, supervisor stays 0.
//  eret with supervisor=1 -> exCtl Jump=11, supervisor=0; eret with supervisor=0 -> illegal exception.

Source files
------------

// File: rtl/pipe_ctl.sv
// Pipelined control for the 5-stage MIPS core: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use stall insertion and exception entry / ERET sequencing with a supervisor-mode bit.
module pipe_ctl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int IRQ_EN     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq,
  input  logic [5:0]        opCode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              branchTaken,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic              ifIdFlush,
  output logic [11:0]       exCtl,
  output logic [1:0]        memCtl,
  output logic [1:0]        wbCtl,
  output logic              excPcSel,
  output logic              epcWrite,
  output logic              supervisor,
  output logic              illOp
);

  typedef enum logic [1:0] {RUN, STALL, EXC} state_t;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);
  localparam logic       IRQ_ON     = (IRQ_EN != 0);
  localparam logic       MULTI      = (LOAD_STALL > 1);

  state_t state, nextState;
  logic [1:0] stallCnt, nextCnt;

  // decoded ID-stage fields
  logic [1:0] dRegDst;
  logic       dALUSrc;
  logic [4:0] dALUOp;
  logic       dBranch, dBrCtl;
  logic [1:0] dJump;
  logic       dMemWrite, dMemRead, dRegWrite, dMemToReg;
  logic       dIllegal, dEret;

  // pipeline registers
  logic [11:0]       idexEx;
  logic [1:0]        idexMem, idexWb;
  logic [REG_AW-1:0] idexRt;
  logic [1:0]        exmemMem, exmemWb;
  logic [1:0]        memwbWb;

  logic issue, nextSup, nextIll;
  logic pcW, ifW, flush, excSel, epcW;
  logic excCond, hazard;

  always_comb begin
    dRegDst   = 2'b00;
    dALUSrc   = 1'b0;
    dALUOp    = 5'b00000;
    dBranch   = 1'b0;
    dBrCtl    = 1'b0;
    dJump     = 2'b00;
    dMemWrite = 1'b0;
    dMemRead  = 1'b0;
    dRegWrite = 1'b0;
    dMemToReg = 1'b0;
    dIllegal  = 1'b0;
    dEret     = 1'b0;
    case (opCode)
      6'b000000: begin
        case (funct)
          6'b000000: begin dALUOp = 5'b01000; dALUSrc = 1'b1; dRegWrite = 1'b1; end
          6'b000010: begin dALUOp = 5'b01001; dALUSrc = 1'b1; dRegWrite = 1'b1; end
          6'b000011: begin dALUOp = 5'b01011; dALUSrc = 1'b1; dRegWrite = 1'b1; end
          6'b100000: begin dALUOp = 5'b00000; dRegWrite = 1'b1; end
          6'b100010: begin dALUOp = 5'b00001; dRegWrite = 1'b1; end
          6'b100100: begin dALUOp = 5'b11000; dRegWrite = 1'b1; end
          6'b100101: begin dALUOp = 5'b11110; dRegWrite = 1'b1; end
          6'b100110: begin dALUOp = 5'b10110; dRegWrite = 1'b1; end
          6'b100111: begin dALUOp = 5'b10001; dRegWrite = 1'b1; end
          6'b101010: begin dALUOp = 5'b00111; dRegWrite = 1'b1; end
          6'b001000: dJump = 2'b10;
          default:   dIllegal = 1'b1;
        endcase
      end
      6'b000010: dJump = 2'b01;
      6'b000011: begin
        dRegDst = 2'b11; dALUOp = 5'b11010; dRegWrite = 1'b1; dJump = 2'b01;
      end
      6'b000100: begin dALUOp = 5'b00001; dBranch = 1'b1; end
      6'b000101: begin dALUOp = 5'b00001; dBranch = 1'b1; dBrCtl = 1'b1; end
      6'b001000: begin dRegDst = 2'b01; dALUSrc = 1'b1; dRegWrite = 1'b1; dALUOp = 5'b00000; end
      6'b001100: begin dRegDst = 2'b01; dALUSrc = 1'b1; dRegWrite = 1'b1; dALUOp = 5'b11000; end
      6'b001101: begin dRegDst = 2'b01; dALUSrc = 1'b1; dRegWrite = 1'b1; dALUOp = 5'b11110; end
      6'b001110: begin dRegDst = 2'b01; dALUSrc = 1'b1; dRegWrite = 1'b1; dALUOp = 5'b10110; end
      6'b100011: begin
        dRegDst = 2'b01; dALUSrc = 1'b1; dRegWrite = 1'b1; dMemRead = 1'b1; dMemToReg = 1'b1;
      end
      6'b101011: begin dALUSrc = 1'b1; dMemWrite = 1'b1; end
      6'b010000: begin
        if (funct == 6'b011000 && supervisor) begin
          dJump = 2'b11;
          dEret = 1'b1;
        end else begin
          dIllegal = 1'b1;
        end
      end
      default: dIllegal = 1'b1;
    endcase
  end

  assign excCond = dIllegal | (irq & IRQ_ON & ~supervisor);
  assign hazard  = idexMem[0] & ((idexRt == rs) | (idexRt == rt)) & (idexRt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      stallCnt <= '0;
    end else begin
      state    <= nextState;
      stallCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = stallCnt;
    issue     = 1'b0;
    nextSup   = supervisor;
    nextIll   = 1'b0;
    pcW       = 1'b1;
    ifW       = 1'b1;
    flush     = 1'b0;
    excSel    = 1'b0;
    epcW      = 1'b0;
    if (branchTaken) begin
      flush     = 1'b1;
      nextCnt   = '0;
      nextState = RUN;
    end else begin
      case (state)
        RUN: begin
          if (excCond) begin
            excSel    = 1'b1;
            epcW      = 1'b1;
            flush     = 1'b1;
            nextIll   = dIllegal;
            nextSup   = 1'b1;
            nextState = EXC;
          end else if (hazard) begin
            pcW       = 1'b0;
            ifW       = 1'b0;
            nextCnt   = STALL_INIT;
            nextState = MULTI ? STALL : RUN;
          end else begin
            issue = 1'b1;
            if (dEret) nextSup = 1'b0;
          end
        end
        STALL: begin
          pcW     = 1'b0;
          ifW     = 1'b0;
          nextCnt = stallCnt - 2'd1;
          if (stallCnt <= 2'd1) nextState = RUN;
        end
        // the slot after exception entry holds the flushed IF/ID entry; keep it a bubble
        EXC:     nextState = RUN;
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idexEx     <= '0;
      idexMem    <= '0;
      idexWb     <= '0;
      idexRt     <= '0;
      exmemMem   <= '0;
      exmemWb    <= '0;
      memwbWb    <= '0;
      supervisor <= 1'b0;
      illOp      <= 1'b0;
    end else begin
      if (issue) begin
        idexEx  <= {dRegDst, dALUSrc, dALUOp, dBranch, dBrCtl, dJump};
        idexMem <= {dMemWrite, dMemRead};
        idexWb  <= {dRegWrite, dMemToReg};
        idexRt  <= rt;
      end else begin
        idexEx  <= '0;
        idexMem <= '0;
        idexWb  <= '0;
        idexRt  <= '0;
      end
      exmemMem   <= idexMem;
      exmemWb    <= idexWb;
      memwbWb    <= exmemWb;
      supervisor <= nextSup;
      illOp      <= nextIll;
    end
  end

  assign exCtl     = idexEx;
  assign memCtl    = exmemMem;
  assign wbCtl     = memwbWb;
  assign pcWrite   = pcW & ~reset;
  assign ifIdWrite = ifW & ~reset;
  assign ifIdFlush = flush & ~reset;
  assign excPcSel  = excSel & ~reset;
  assign epcWrite  = epcW & ~reset;

endmodule

// File: tb/tb_pipe_ctl.sv
// Scoreboard bench for pipe_ctl: two instances (LOAD_STALL=1 and 3) on shared stimulus, each checked
// every cycle against a behavioural model of the control rules.
module tb_pipe_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1, irq = 1'b0, branchTaken = 1'b0;
  logic [5:0] opCode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0;

  typedef struct packed {
    logic        pcWrite, ifIdWrite, ifIdFlush;
    logic [11:0] exCtl;
    logic [1:0]  memCtl, wbCtl;
    logic        excPcSel, epcWrite, supervisor, illOp;
  } obs_t;

  typedef struct packed {
    logic        legal, eret;
    logic [11:0] ex;
    logic [1:0]  mem, wb;
  } dec_t;

  typedef struct packed {
    logic [11:0] ex;
    logic [1:0]  mem, wb;
    logic [4:0]  rt;
    logic [1:0]  exmemMem, exmemWb, memwbWb;
    logic [1:0]  bubblesLeft;
    logic        inExc, sup, ill;
  } mstate_t;

  obs_t a1, a3;
  obs_t q1[$], q3[$];
  mstate_t m1, m3;
  int vectors = 0, miscompares = 0, cycle = 0;

  always #5 clk = ~clk;

  pipe_ctl #(.REG_AW(5), .LOAD_STALL(1), .IRQ_EN(1)) dut1 (
    .clk(clk), .reset(reset), .irq(irq), .opCode(opCode), .funct(funct), .rs(rs), .rt(rt),
    .branchTaken(branchTaken), .pcWrite(a1.pcWrite), .ifIdWrite(a1.ifIdWrite),
    .ifIdFlush(a1.ifIdFlush), .exCtl(a1.exCtl), .memCtl(a1.memCtl), .wbCtl(a1.wbCtl),
    .excPcSel(a1.excPcSel), .epcWrite(a1.epcWrite), .supervisor(a1.supervisor), .illOp(a1.illOp));

  pipe_ctl #(.REG_AW(5), .LOAD_STALL(3), .IRQ_EN(1)) dut3 (
    .clk(clk), .reset(reset), .irq(irq), .opCode(opCode), .funct(funct), .rs(rs), .rt(rt),
    .branchTaken(branchTaken), .pcWrite(a3.pcWrite), .ifIdWrite(a3.ifIdWrite),
    .ifIdFlush(a3.ifIdFlush), .exCtl(a3.exCtl), .memCtl(a3.memCtl), .wbCtl(a3.wbCtl),
    .excPcSel(a3.excPcSel), .epcWrite(a3.epcWrite), .supervisor(a3.supervisor), .illOp(a3.illOp));

  // instruction table: control expressed as named fields, packed only at the end
  function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic sup);
    dec_t d;
    logic [1:0] regDst, jump;
    logic aluSrc, br, brNe, memW, memR, regW, memToReg, ok, isEret;
    logic [4:0] aluOp;
    regDst = 2'b00; jump = 2'b00; aluSrc = 0; br = 0; brNe = 0; memW = 0; memR = 0;
    regW = 0; memToReg = 0; ok = 1; isEret = 0; aluOp = 5'b00000;
    if (op == 6'd0) begin
      regW = 1;
      case (fn)
        6'b000000: begin aluOp = 5'b01000; aluSrc = 1; end
        6'b000010: begin aluOp = 5'b01001; aluSrc = 1; end
        6'b000011: begin aluOp = 5'b01011; aluSrc = 1; end
        6'b100000: aluOp = 5'b00000;
        6'b100010: aluOp = 5'b00001;
        6'b100100: aluOp = 5'b11000;
        6'b100101: aluOp = 5'b11110;
        6'b100110: aluOp = 5'b10110;
        6'b100111: aluOp = 5'b10001;
        6'b101010: aluOp = 5'b00111;
        6'b001000: begin regW = 0; jump = 2'b10; end
        default:   begin regW = 0; ok = 0; end
      endcase
    end else begin
      case (op)
        6'b000010: jump = 2'b01;
        6'b000011: begin regDst = 2'b11; aluOp = 5'b11010; regW = 1; jump = 2'b01; end
        6'b000100: begin aluOp = 5'b00001; br = 1; end
        6'b000101: begin aluOp = 5'b00001; br = 1; brNe = 1; end
        6'b001000, 6'b001100, 6'b001101, 6'b001110: begin
          regDst = 2'b01; aluSrc = 1; regW = 1;
          aluOp = (op == 6'b001000) ? 5'b00000 : (op == 6'b001100) ? 5'b11000 :
                  (op == 6'b001101) ? 5'b11110 : 5'b10110;
        end
        6'b100011: begin regDst = 2'b01; aluSrc = 1; regW = 1; memR = 1; memToReg = 1; end
        6'b101011: begin aluSrc = 1; memW = 1; end
        6'b010000: if (fn == 6'b011000 && sup) begin jump = 2'b11; isEret = 1; end else ok = 0;
        default:   ok = 0;
      endcase
    end
    d.legal = ok;
    d.eret  = isEret;
    d.ex    = ok ? {regDst, aluSrc, aluOp, br, brNe, jump} : 12'd0;
    d.mem   = ok ? {memW, memR} : 2'd0;
    d.wb    = ok ? {regW, memToReg} : 2'd0;
    return d;
  endfunction

  // one clock period of the control rules: outputs seen this cycle, state after the next edge
  task automatic model_step(input mstate_t s, input int loadStall, output obs_t o, output mstate_t n);
    dec_t d;
    logic useHaz, enter;
    d = ref_decode(opCode, funct, s.sup);
    o = '0;
    n = '0;
    if (reset) return;
    o.exCtl = s.ex; o.memCtl = s.exmemMem; o.wbCtl = s.memwbWb;
    o.supervisor = s.sup; o.illOp = s.ill;
    o.pcWrite = 1; o.ifIdWrite = 1;
    n.exmemMem = s.mem; n.exmemWb = s.wb; n.memwbWb = s.exmemWb;
    n.sup = s.sup;
    n.bubblesLeft = s.bubblesLeft;
    useHaz = s.mem[0] && s.rt != 0 && (s.rt == rs || s.rt == rt);
    enter  = !d.legal || (irq && !s.sup);
    if (branchTaken) begin
      o.ifIdFlush = 1;
      n.bubblesLeft = 0;
    end else if (s.inExc) begin
      // bubble slot following exception entry
    end else if (s.bubblesLeft != 0) begin
      o.pcWrite = 0; o.ifIdWrite = 0;
      n.bubblesLeft = s.bubblesLeft - 1;
    end else if (enter) begin
      o.excPcSel = 1; o.epcWrite = 1; o.ifIdFlush = 1;
      n.ill = !d.legal; n.sup = 1; n.inExc = 1;
    end else if (useHaz) begin
      o.pcWrite = 0; o.ifIdWrite = 0;
      n.bubblesLeft = 2'(loadStall - 1);
    end else begin
      n.ex = d.ex; n.mem = d.mem; n.wb = d.wb; n.rt = rt;
      if (d.eret) n.sup = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic i, input logic b, input logic [5:0] op,
                     input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t);
    obs_t e1, e3;
    mstate_t n1, n3;
    @(posedge clk);
    #1;
    reset = r; irq = i; branchTaken = b; opCode = op; funct = fn; rs = s; rt = t;
    model_step(m1, 1, e1, n1);
    model_step(m3, 3, e3, n3);
    m1 = n1; m3 = n3;
    q1.push_back(e1);
    q3.push_back(e3);
  endtask

  always @(negedge clk) begin
    obs_t e;
    cycle++;
    if (q1.size() != 0) begin
      e = q1.pop_front();
      vectors++;
      if (a1 !== e) begin
        miscompares++;
        $display("FAIL ls1_outputs cycle %0d: got %h expected %h", cycle, a1, e);
      end
    end
    if (q3.size() != 0) begin
      e = q3.pop_front();
      vectors++;
      if (a3 !== e) begin
        miscompares++;
        $display("FAIL ls3_outputs cycle %0d: got %h expected %h", cycle, a3, e);
      end
    end
  end

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_ERET = 6'b010000, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_ERET = 6'b011000;

  logic [5:0] rFuncs[11] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b001000};
  logic [5:0] iOps[11] = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
                           6'b001101, 6'b001110, 6'b100011, 6'b101011, 6'b100011};

  initial begin
    logic [5:0] op, fn;
    int k;
    m1 = '0; m3 = '0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // lw $2 followed by a dependent add
    cyc(0, 0, 0, OP_LW, 0, 1, 2);
    repeat (5) cyc(0, 0, 0, OP_R, FN_ADD, 2, 4);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    // load to $0 never stalls
    cyc(0, 0, 0, OP_LW, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, OP_R, FN_ADD, 0, 0);
    // illegal opcode, then eret in supervisor, then eret in user mode
    cyc(0, 0, 0, OP_BAD, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, OP_ERET, FN_ERET, 16, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, OP_ERET, FN_ERET, 16, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, OP_ERET, FN_ERET, 16, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    // branch redirect outranks irq and illegal decode
    cyc(0, 1, 1, OP_BAD, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, OP_R, FN_ADD, 5, 6);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, OP_ERET, FN_ERET, 16, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    // reset lands while the LOAD_STALL=3 instance is stalling
    cyc(0, 0, 0, OP_LW, 0, 1, 2);
    cyc(0, 0, 0, OP_R, FN_ADD, 2, 4);
    cyc(1, 0, 0, OP_R, FN_ADD, 2, 4);
    cyc(1, 0, 0, OP_R, FN_ADD, 2, 4);
    repeat (3) cyc(0, 0, 0, OP_R, FN_ADD, 2, 4);
    // randomized traffic with small register numbers to provoke hazards
    repeat (3000) begin
      k = int'($urandom_range(0, 23));
      fn = 6'($urandom);
      if (k < 8)       begin op = OP_R; fn = rFuncs[$urandom_range(0, 10)]; end
      else if (k < 19) op = iOps[k - 8];
      else if (k < 21) begin op = OP_ERET; if ($urandom_range(0, 3) != 0) fn = FN_ERET; end
      else             op = 6'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
          op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #1;
    reset = 1'b0; irq = 1'b0; branchTaken = 1'b0; opCode = '0; funct = '0;
    repeat (3) @(negedge clk);
    #1;
    if (q1.size() != 0 || q3.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d entries left, required 0", q1.size(), q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
